// File: rtl/fpu_pkg.sv
// Shared FPU encodings and constants: rounding modes, special-value kinds,
// fflags bit positions, FP32 constants and the divide back-end S1 payload.
package fpu_pkg;

    localparam int unsigned QW   = 26;
    localparam int unsigned EW   = 10;
    localparam int unsigned EXW  = EW + 2;
    localparam int unsigned MW   = 24;
    localparam int unsigned BIAS = 127;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    typedef enum logic [1:0] {
        KIND_NORM = 2'b00,
        KIND_ZERO = 2'b01,
        KIND_INF  = 2'b10,
        KIND_NAN  = 2'b11
    } kind_e;

    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_MAXF = 32'h7F7F_FFFF;

    // Normalized item held between normalize and round/pack
    typedef struct packed {
        logic           sign;
        logic [EXW-1:0] exp;
        logic [MW-1:0]  mant;
        logic           g;
        logic           s;
        kind_e          kind;
        logic           dz;
        logic           nv;
        logic [2:0]     rm;
    } s1_t;

    // Overflow saturates to infinity unless rounding is directed away from it
    function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
        logic r;
        case (rm)
            RM_RTZ:  r = 1'b0;
            RM_RDN:  r = sign;
            RM_RUP:  r = ~sign;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fdiv_round_unit.sv
// Combinational mantissa rounder: applies the RISC-V rounding mode to a
// 24-bit mantissa with guard/sticky, reporting carry-out and inexact.
module fdiv_round_unit
    import fpu_pkg::*;
(
    input  logic [MW-1:0] i_mant,
    input  logic          i_g,
    input  logic          i_s,
    input  logic          i_sign,
    input  logic [2:0]    i_rm,
    output logic [MW-1:0] o_mant,
    output logic          o_carry,
    output logic          o_inexact
);

    logic        w_inc;
    logic [MW:0] w_sum;

    always_comb begin
        w_inc = 1'b0;
        case (i_rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = i_sign & (i_g | i_s);
            RM_RUP:  w_inc = ~i_sign & (i_g | i_s);
            RM_RMM:  w_inc = i_g;
            default: w_inc = i_g & (i_s | i_mant[0]);
        endcase
    end

    assign w_sum     = {1'b0, i_mant} + (MW+1)'(w_inc);
    assign o_carry   = w_sum[MW];
    assign o_mant    = o_carry ? w_sum[MW:1] : w_sum[MW-1:0];
    assign o_inexact = i_g | i_s;

endmodule

// File: rtl/fdiv_norm_round.sv
// FP32 divide back end: S1 normalizes the raw quotient, S2 rounds and packs.
// Define FDIV_SUBNORMAL_EN for gradual underflow; default flushes to zero.
module fdiv_norm_round
    import fpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic [QW-1:0] in_quot,
    input  logic          in_sticky,
    input  logic [1:0]    in_kind,
    input  logic          in_dz,
    input  logic          in_nv,
    input  logic [2:0]    in_rm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic [4:0]    out_flags
);

    logic           r_s1_v;
    s1_t            r_s1;
    logic           r_out_valid;
    logic [31:0]    r_out_result;
    logic [4:0]     r_out_flags;

    logic           w_s1_adv;
    logic           w_s2_adv;
    s1_t            w_s1_d;
    logic [EXW-1:0] w_exp_ext;

    assign w_s2_adv = ~r_out_valid | out_ready;
    assign w_s1_adv = ~r_s1_v | w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_exp_ext = {{(EXW-EW){in_exp[EW-1]}}, in_exp};

    // Normalize: quotient in [0.5,2) needs at most a one-bit left shift
    always_comb begin
        w_s1_d.sign = in_sign;
        w_s1_d.kind = kind_e'(in_kind);
        w_s1_d.dz   = in_dz;
        w_s1_d.nv   = in_nv;
        w_s1_d.rm   = in_rm;
        if (in_quot[QW-1]) begin
            w_s1_d.mant = in_quot[QW-1:2];
            w_s1_d.g    = in_quot[1];
            w_s1_d.s    = in_quot[0] | in_sticky;
            w_s1_d.exp  = w_exp_ext;
        end else begin
            w_s1_d.mant = in_quot[QW-2:1];
            w_s1_d.g    = in_quot[0];
            w_s1_d.s    = in_sticky;
            w_s1_d.exp  = w_exp_ext - EXW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s1   <= '0;
        end else if (w_s1_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1 <= w_s1_d;
            end
        end
    end

    logic          w_tiny;
    logic [MW-1:0] w_rnd_mant;
    logic          w_rnd_g;
    logic          w_rnd_s;

    assign w_tiny = r_s1.exp[EXW-1] | (r_s1.exp == '0);

`ifdef FDIV_SUBNORMAL_EN
    logic [EXW-1:0]  w_dist;
    logic [4:0]      w_sh;
    logic [2*MW+1:0] w_shv;

    // Denormalize: shift by 1-e, capped once every mantissa bit is sticky
    assign w_dist     = EXW'(1) - r_s1.exp;
    assign w_sh       = (w_dist > EXW'(MW+1)) ? 5'(MW+1) : w_dist[4:0];
    assign w_shv      = {r_s1.mant, r_s1.g, (MW+1)'(0)} >> w_sh;
    assign w_rnd_mant = w_tiny ? w_shv[2*MW+1:MW+2] : r_s1.mant;
    assign w_rnd_g    = w_tiny ? w_shv[MW+1] : r_s1.g;
    assign w_rnd_s    = w_tiny ? (r_s1.s | (|w_shv[MW:0])) : r_s1.s;
`else
    assign w_rnd_mant = r_s1.mant;
    assign w_rnd_g    = r_s1.g;
    assign w_rnd_s    = r_s1.s;
`endif

    logic [MW-1:0]  w_mant_o;
    logic           w_carry;
    logic           w_inexact;

    fdiv_round_unit u_round (
        .i_mant    (w_rnd_mant),
        .i_g       (w_rnd_g),
        .i_s       (w_rnd_s),
        .i_sign    (r_s1.sign),
        .i_rm      (r_s1.rm),
        .o_mant    (w_mant_o),
        .o_carry   (w_carry),
        .o_inexact (w_inexact)
    );

    logic [EXW-1:0] w_e_fin;
    logic           w_ovf;
    logic [7:0]     w_exp_field;
    logic [31:0]    w_res;
    logic [4:0]     w_flags;
    logic           w_of;
    logic           w_uf;
    logic           w_nx;

    assign w_e_fin = r_s1.exp + EXW'(w_carry);
    assign w_ovf   = ~w_e_fin[EXW-1] & (w_e_fin >= EXW'(255));

    // Hidden bit folds into the exponent field: a subnormal rounding up to
    // 2^23 becomes the minimum normal with no special casing
    assign w_exp_field = (w_tiny ? 8'd0 : (w_e_fin[7:0] - 8'd1)) + 8'(w_mant_o[MW-1]);

    always_comb begin
        w_res = '0;
        w_of  = 1'b0;
        w_uf  = 1'b0;
        w_nx  = 1'b0;
        case (r_s1.kind)
            KIND_ZERO: w_res = {r_s1.sign, 31'b0};
            KIND_INF:  w_res = {r_s1.sign, 8'hFF, 23'b0};
            KIND_NAN:  w_res = FP32_QNAN;
            default: begin
                if (w_tiny) begin
`ifdef FDIV_SUBNORMAL_EN
                    w_nx  = w_inexact;
                    w_uf  = w_inexact & ~w_mant_o[MW-1];
                    w_res = {r_s1.sign, w_exp_field, w_mant_o[MW-2:0]};
`else
                    w_nx  = 1'b1;
                    w_uf  = 1'b1;
                    w_res = {r_s1.sign, 31'b0};
`endif
                end else if (w_ovf) begin
                    w_of  = 1'b1;
                    w_nx  = 1'b1;
                    w_res = ovf_to_inf(r_s1.rm, r_s1.sign) ? {r_s1.sign, 8'hFF, 23'b0}
                                                          : {r_s1.sign, FP32_MAXF[30:0]};
                end else begin
                    w_nx  = w_inexact;
                    w_res = {r_s1.sign, w_exp_field, w_mant_o[MW-2:0]};
                end
            end
        endcase
        w_flags          = '0;
        w_flags[FLAG_NV] = r_s1.nv;
        w_flags[FLAG_DZ] = r_s1.dz;
        w_flags[FLAG_OF] = w_of;
        w_flags[FLAG_UF] = w_uf;
        w_flags[FLAG_NX] = w_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_v;
            if (r_s1_v) begin
                r_out_result <= w_res;
                r_out_flags  <= w_flags;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;

endmodule
